// File: rtl/adpll_pkg.sv
// Shared constants for the all-digital PLL blocks (ID counter, loop filter,
// phase detector) plus small constant helpers for counter sizing.
package adpll_pkg;

    // Default DCO nominal half-period in clk cycles.
    localparam int HALF_DEF         = 2;
    // Default fb_out period in id_out periods.
    localparam int N_DEF            = 8;
    // Default width of the signed pending-correction counter.
    localparam int PEND_W_DEF       = 3;
    // Default quiet fb_out periods before lock asserts.
    localparam int LOCK_PERIODS_DEF = 16;

    // Largest magnitude the pending-correction counter may hold.
    function automatic int pend_max_f(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int PEND_MAX = (1 << (PEND_W_DEF - 1)) - 1;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/id_counter_if.sv
// ID counter connection bundle: loop-filter pulses in, DCO outputs back.
// master = loop-filter / test side, slave = id_counter.
interface id_counter_if;

    logic carry;
    logic borrow;
    logic id_out;
    logic fb_out;
    logic lock;

    modport master (
        output carry,
        output borrow,
        input  id_out,
        input  fb_out,
        input  lock
    );

    modport slave (
        input  carry,
        input  borrow,
        output id_out,
        output fb_out,
        output lock
    );

endinterface

// File: rtl/id_fb_divider.sv
// Divide-by-N toggle divider: counts toggle strobes 0..N-1 and flips fb_out
// on the strobe that wraps the count. Output is a direct flop.
import adpll_pkg::*;

module id_fb_divider #(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tog_i,
    output logic fb_out
);

    localparam int TC_W = cnt_width(N - 1);

    logic [TC_W-1:0] tog_cnt_q;
    logic [TC_W-1:0] tog_cnt_d;
    logic            fb_q;
    logic            fb_d;

    // Next-state: advance the toggle count, wrap and flip fb_out at N-1.
    always_comb begin
        tog_cnt_d = tog_cnt_q;
        fb_d      = fb_q;
        if (tog_i) begin
            if (tog_cnt_q == TC_W'(N - 1)) begin
                tog_cnt_d = '0;
                fb_d      = ~fb_q;
            end else begin
                tog_cnt_d = tog_cnt_q + TC_W'(1);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tog_cnt_q <= '0;
            fb_q      <= 1'b0;
        end else begin
            tog_cnt_q <= tog_cnt_d;
            fb_q      <= fb_d;
        end
    end

    assign fb_out = fb_q;

endmodule

// File: rtl/id_counter.sv
// Increment/decrement counter of the all-digital PLL. Carry rising edges
// shorten, borrow falling edges stretch, one id_out half-period each by one
// clk; pending corrections are held in a saturating signed counter and
// applied one per half-period. fb_out is id_out divided by N.
// Optional build macro: ID_LOCK_DETECT_EN adds the loop-quiet lock detector;
// without it lock is constant 0.
import adpll_pkg::*;

module id_counter #(
    parameter int HALF         = HALF_DEF,
    parameter int N            = N_DEF,
    parameter int PEND_W       = PEND_W_DEF,
    parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    id_counter_if.slave  bus
);

    localparam int HC_W  = cnt_width(HALF + 1);
    localparam int P_MAX = pend_max_f(PEND_W);

    // Reject parameter sets the half-period engine cannot honour.
    if (HALF < 2 || N < 1 || PEND_W < 2 || LOCK_PERIODS < 1) begin : g_param_check
        $error("id_counter: illegal parameter set");
    end

    logic                     carry_q;
    logic                     carry_d;
    logic                     borrow_q;
    logic                     borrow_d;
    logic signed [PEND_W-1:0] net_q;
    logic signed [PEND_W-1:0] net_d;
    logic [HC_W-1:0]          half_cnt_q;
    logic [HC_W-1:0]          half_cnt_d;
    logic                     id_out_q;
    logic                     id_out_d;
    logic                     inc;
    logic                     dec;
    logic                     tog;
    int                       net_i;
    logic                     fb_q;

    // Edge detect, correction bookkeeping and half-period reload.
    always_comb begin
        carry_d  = bus.carry;
        borrow_d = bus.borrow;
        inc      = bus.carry & ~carry_q;
        dec      = ~bus.borrow & borrow_q;
        tog      = (half_cnt_q == HC_W'(1));
        id_out_d = id_out_q ^ tog;

        half_cnt_d = half_cnt_q - HC_W'(1);
        net_i      = int'(net_q);

        // The reload consumes one pending correction, decided on the
        // registered net so a same-cycle event lands in the next half-period.
        if (tog) begin
            if (net_q > 0) begin
                half_cnt_d = HC_W'(HALF - 1);
                net_i      = net_i - 1;
            end else if (net_q < 0) begin
                half_cnt_d = HC_W'(HALF + 1);
                net_i      = net_i + 1;
            end else begin
                half_cnt_d = HC_W'(HALF);
            end
        end

        // Coincident inc and dec cancel; saturation drops excess events.
        if (inc && !dec) begin
            net_i = net_i + 1;
        end else if (dec && !inc) begin
            net_i = net_i - 1;
        end
        if (net_i > P_MAX) begin
            net_i = P_MAX;
        end else if (net_i < -P_MAX) begin
            net_i = -P_MAX;
        end
        net_d = net_i[PEND_W-1:0];
    end

    // Edge-detect history, pending corrections and DCO half-period engine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q    <= 1'b0;
            borrow_q   <= 1'b1;
            net_q      <= '0;
            half_cnt_q <= HC_W'(HALF);
            id_out_q   <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            net_q      <= net_d;
            half_cnt_q <= half_cnt_d;
            id_out_q   <= id_out_d;
        end
    end

    id_fb_divider #(
        .N (N)
    ) u_fb_div (
        .clk    (clk),
        .reset  (reset),
        .tog_i  (tog),
        .fb_out (fb_q)
    );

    assign bus.id_out = id_out_q;
    assign bus.fb_out = fb_q;

`ifdef ID_LOCK_DETECT_EN
    localparam int QC_W = cnt_width(LOCK_PERIODS);

    logic            fb_prev_q;
    logic            fb_prev_d;
    logic [QC_W-1:0] quiet_cnt_q;
    logic [QC_W-1:0] quiet_cnt_d;
    logic            lock_q;
    logic            lock_d;

    // Count quiet fb_out rising edges; any loop event restarts the count.
    always_comb begin
        fb_prev_d   = fb_q;
        quiet_cnt_d = quiet_cnt_q;
        if (inc || dec) begin
            quiet_cnt_d = '0;
        end else if (fb_q && !fb_prev_q && (quiet_cnt_q != QC_W'(LOCK_PERIODS))) begin
            quiet_cnt_d = quiet_cnt_q + QC_W'(1);
        end
        lock_d = (quiet_cnt_d == QC_W'(LOCK_PERIODS));
    end

    // Lock detector registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_prev_q   <= 1'b0;
            quiet_cnt_q <= '0;
            lock_q      <= 1'b0;
        end else begin
            fb_prev_q   <= fb_prev_d;
            quiet_cnt_q <= quiet_cnt_d;
            lock_q      <= lock_d;
        end
    end

    assign bus.lock = lock_q;
`else
    assign bus.lock = 1'b0;
`endif

endmodule

// File: tb/tb_id_counter.sv
// Directed bench for id_counter: table of carry/borrow patterns with
// hand-computed half-period sequences, plus saturation, async reset and
// lock sequences.
module tb_id_counter;

    typedef struct {
        string       name;
        logic [39:0] carry_pat;
        logic [39:0] borrow_low;
        int          exp_hp[6];
        int          exp_fb1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_counter_if bus_a ();
    id_counter_if bus_b ();

    id_counter #(.HALF(2),  .N(8), .PEND_W(3), .LOCK_PERIODS(16)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    id_counter #(.HALF(12), .N(8), .PEND_W(3), .LOCK_PERIODS(16)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] rm(input int lo, input int hi);
        logic [39:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(input string nm, input logic [39:0] cp, input logic [39:0] bl,
                                input int h0, input int h1, input int h2, input int h3,
                                input int h4, input int h5, input int fb1);
        vec_t v;
        v.name       = nm;
        v.carry_pat  = cp;
        v.borrow_low = bl;
        v.exp_hp     = '{h0, h1, h2, h3, h4, h5};
        v.exp_fb1    = fb1;
        return v;
    endfunction

    // Reset dut_a for 3 clk and release it #1 after a rising edge.
    task automatic reset_a();
        rst_a        = 1'b0;
        bus_a.carry  = 1'b0;
        bus_a.borrow = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
    endtask

    task automatic reset_b();
        rst_b        = 1'b0;
        bus_b.carry  = 1'b0;
        bus_b.borrow = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   tt[16];
        int   nt;
        int   fb1;
        int   lock_seen;
        logic prev_id;
        logic prev_fb;
        reset_a();
        nt        = 0;
        fb1       = -1;
        lock_seen = 0;
        prev_id   = bus_a.id_out;
        prev_fb   = bus_a.fb_out;
        for (int k = 1; k < 40; k++) begin
            bus_a.carry  = v.carry_pat[k];
            bus_a.borrow = ~v.borrow_low[k];
            @(posedge clk);
            #1;
            if (bus_a.id_out !== prev_id && nt < 16) begin
                tt[nt] = k;
                nt++;
            end
            if (bus_a.fb_out !== prev_fb && fb1 < 0) fb1 = k;
            if (bus_a.lock !== 1'b0) lock_seen = 1;
            prev_id = bus_a.id_out;
            prev_fb = bus_a.fb_out;
        end
        chk({v.name, "_toggles"}, int'(nt >= 6), 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_hp%0d", v.name, i),
                (i < nt) ? (tt[i] - ((i == 0) ? 0 : tt[i-1])) : -1, v.exp_hp[i]);
        end
        chk({v.name, "_fb_first_toggle"}, fb1, v.exp_fb1);
        chk({v.name, "_net_end"}, int'(dut_a.net_q), 0);
        chk({v.name, "_lock_low"}, lock_seen, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   tt[8];
        int   nt;
        int   lock_edge;
        logic prev_id;

        vecs[0] = mk("free_run",     '0,                   '0,        2, 2, 2, 2, 2, 2, 16);
        vecs[1] = mk("carry_e3",     rm(3, 3),             '0,        2, 2, 1, 2, 2, 2, 15);
        vecs[2] = mk("carry_e4",     rm(4, 4),             '0,        2, 2, 2, 1, 2, 2, 15);
        vecs[3] = mk("borrow_5clk",  '0,                   rm(3, 7),  2, 2, 3, 2, 2, 2, 17);
        vecs[4] = mk("simultaneous", rm(3, 3),             rm(3, 3),  2, 2, 2, 2, 2, 2, 16);
        vecs[5] = mk("carry_held",   rm(3, 8),             '0,        2, 2, 1, 2, 2, 2, 15);
        vecs[6] = mk("two_carries",  rm(3, 3) | rm(5, 5),  '0,        2, 2, 1, 2, 1, 2, 14);

        // Reset values while reset is held.
        rst_a        = 1'b0;
        rst_b        = 1'b0;
        bus_a.carry  = 1'b0;
        bus_a.borrow = 1'b1;
        bus_b.carry  = 1'b0;
        bus_b.borrow = 1'b1;
        @(negedge clk);
        chk("rst_id_out",   int'(bus_a.id_out), 0);
        chk("rst_fb_out",   int'(bus_a.fb_out), 0);
        chk("rst_lock",     int'(bus_a.lock),   0);
        chk("rst_net",      int'(dut_a.net_q),  0);
        chk("rst_half_cnt", int'(dut_a.half_cnt_q), 2);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Saturation on the HALF=12 instance: carries on edges 1,3,5,7,9.
        reset_b();
        nt      = 0;
        prev_id = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            bus_b.carry = (k <= 9) ? k[0] : 1'b0;
            @(posedge clk);
            #1;
            if (k == 5) chk("sat_net_e5", int'(dut_b.net_q), 3);
            if (k == 9) chk("sat_net_e9", int'(dut_b.net_q), 3);
            if (bus_b.id_out !== prev_id && nt < 8) begin
                tt[nt] = k;
                nt++;
            end
            prev_id = bus_b.id_out;
        end
        chk("sat_toggles", int'(nt >= 5), 1);
        chk("sat_hp0", (nt > 0) ? tt[0] : -1, 12);
        chk("sat_hp1", (nt > 1) ? tt[1] - tt[0] : -1, 11);
        chk("sat_hp2", (nt > 2) ? tt[2] - tt[1] : -1, 11);
        chk("sat_hp3", (nt > 3) ? tt[3] - tt[2] : -1, 11);
        chk("sat_hp4", (nt > 4) ? tt[4] - tt[3] : -1, 12);

        // Reset mid-operation while net=2 and id_out=1.
        reset_b();
        for (int k = 1; k <= 15; k++) begin
            bus_b.carry = (k <= 9) ? k[0] : 1'b0;
            @(posedge clk);
            #1;
        end
        chk("midrst_net_before", int'(dut_b.net_q), 2);
        chk("midrst_id_before",  int'(bus_b.id_out), 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("midrst_net",    int'(dut_b.net_q),      0);
        chk("midrst_id_out", int'(bus_b.id_out),     0);
        chk("midrst_half",   int'(dut_b.half_cnt_q), 12);
        rst_b = 1'b1;

        // Lock behaviour on the HALF=2 instance.
        reset_a();
        lock_edge = -1;
        for (int k = 1; k <= 800 && lock_edge < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus_a.lock === 1'b1) lock_edge = k;
        end
`ifdef ID_LOCK_DETECT_EN
        chk("lock_not_early", int'(lock_edge >= 496), 1);
        chk("lock_in_time",   int'(lock_edge > 0 && lock_edge <= 497), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("lock_holds", int'(bus_a.lock), 1);
        bus_a.carry = 1'b1;
        @(posedge clk);
        #1;
        bus_a.carry = 1'b0;
        chk("lock_clear_on_carry", int'(bus_a.lock), 0);
`else
        chk("lock_const_zero", lock_edge, -1);
        chk("lock_low_end", int'(bus_a.lock), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
